// File: rtl/gpio_ctrl_intr_arbiter.sv
// gpio_ctrl_intr_arbiter
//   Sequences per-bank GPIO interrupt requests toward the system interrupt
//   controller. A request first waits out an optional coalescing hold-off.
//   Round-robin then picks one bank, which is presented with a valid/ack
//   handshake. The arbiter then waits for software's end-of-interrupt, with a
//   bounded timeout. Only one bank is in service at any time.
module gpio_ctrl_intr_arbiter #(
  parameter int NUM_BANKS   = 8,
  parameter int HOLDOFF_W   = 8,
  parameter int EOI_TIMEOUT = 1024,
  localparam int ID_W       = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] bank_irq,
  input  logic [NUM_BANKS-1:0] bank_mask,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  output logic                 irq_valid,
  output logic [ID_W-1:0]      irq_bank_id,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 eoi_timeout,
  output logic                 spurious,
  output logic                 busy
);

  localparam int TMO_W = $clog2(EOI_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLDOFF = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_SERVICE = 2'd3;

  logic [1:0]           r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [HOLDOFF_W-1:0] r_cnt;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_valid;
  logic [ID_W-1:0]      r_bank_id;
  logic                 r_eoi_timeout;
  logic                 r_spurious;
  logic                 r_busy;

  logic [NUM_BANKS-1:0] w_pending;
  logic                 w_any_pending;
  logic [ID_W-1:0]      w_pick_id;

  // Round-robin search: the first pending bank after ptr, wrapping around.
  // The caller only uses the result when at least one bank is pending.
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [NUM_BANKS-1:0] pend,
                                                input logic [ID_W-1:0]      ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    // NOTE: every local gets a value before the loop, so no path leaves one holding a stale value.
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      idx = (int'(ptr) + i) % NUM_BANKS;
      if (!found && pend[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
    return pick;
  endfunction

  // Masking acts immediately, including on a bank that is already being presented.
  assign w_pending     = bank_irq & ~bank_mask;
  assign w_any_pending = |w_pending;
  assign w_pick_id     = f_rr_pick(w_pending, r_rr_ptr);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with <= so every register sees the same pre-edge values.
      r_state       <= ST_IDLE;
      r_rr_ptr      <= ID_W'(NUM_BANKS - 1);
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_valid       <= 1'b0;
      r_bank_id     <= '0;
      r_eoi_timeout <= 1'b0;
      r_spurious    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_eoi_timeout <= 1'b0;
      r_spurious    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_pending) begin
            r_busy <= 1'b1;
            if (cfg_holdoff == '0) begin
              r_bank_id <= w_pick_id;
              r_valid   <= 1'b1;
              r_state   <= ST_PRESENT;
            end else begin
              // The hold-off length is captured here; later writes wait for the next request.
              r_cnt   <= cfg_holdoff;
              r_state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (!w_any_pending) begin
            // Request vanished while coalescing: back off silently.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == HOLDOFF_W'(1)) begin
            r_bank_id <= w_pick_id;
            r_valid   <= 1'b1;
            r_state   <= ST_PRESENT;
          end else begin
            r_cnt <= r_cnt - HOLDOFF_W'(1);
          end
        end
        ST_PRESENT: begin
          if (irq_ack) begin
            // An ack wins over a simultaneous withdrawal.
            r_valid  <= 1'b0;
            r_rr_ptr <= r_bank_id;
            r_tmo    <= TMO_W'(EOI_TIMEOUT);
            r_state  <= ST_SERVICE;
          end else if (!w_pending[r_bank_id]) begin
            r_valid    <= 1'b0;
            r_spurious <= 1'b1;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            // An EOI wins over a simultaneous expiry.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tmo == TMO_W'(1)) begin
            r_eoi_timeout <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid   = r_valid;
  assign irq_bank_id = r_bank_id;
  assign eoi_timeout = r_eoi_timeout;
  assign spurious    = r_spurious;
  assign busy        = r_busy;

endmodule
